morse_char_display: RTL and testbench
=====================================

// Module: morse_char_display
// PURPOSE
//  Scrolling multi-digit seven-segment driver for decoded Morse characters.
//  Holds the last NUM_DIGITS character codes in a shift buffer; each new code enters the rightmost digit.
//  Time-multiplexes the digits onto one shared active-low segment bus plus per-digit anodes.
//  Sits between the Morse symbol decoder (char_valid/char_code) and the board display pins.
// PARAMETERS
//  NUM_DIGITS   4       number of physical digits / buffer depth (>=2)
//  REFRESH_DIV  100000  clk cycles each digit stays lit (>=2)
//  CODE_W       6       width of char_code
// PORTS
//  clk         in   1                       system clock, all logic on rising edge
//  rst         in   1                       synchronous, active-high reset
//  char_valid  in   1                       one-cycle strobe, char_code is valid this cycle
//  char_code   in   CODE_W                  0-9 = '0'-'9', 10-35 = 'A'-'Z', 63 = blank, 36-62 = invalid
//  clear       in   1                       synchronous buffer clear (display only)
//  an          out  NUM_DIGITS              digit enables, active low; an[0] = rightmost digit
//  seg         out  7                       segments a..g on seg[0]..seg[6], active low
//  dp          out  1                       decimal point, active low
//  char_count  out  $clog2(NUM_DIGITS+1)    number of non-cleared chars held, saturates at NUM_DIGITS
// BEHAVIOUR
//  Reset: buffer all = 63 (blank); char_count = 0; overflow = 0; refresh counter = 0; digit index = 0.
//   Outputs during reset: an = all 1s, seg = 7'h7F, dp = 1.
//  Buffer: on char_valid, buf[i] <= buf[i-1] for i = NUM_DIGITS-1..1, and buf[0] <= char_code.
//   The oldest char is dropped. Every code, including blank and invalid, is stored.
//   char_count increments, saturating at NUM_DIGITS.
//   A char_valid arriving while char_count == NUM_DIGITS sets overflow.
//  clear: all buf <= 63, char_count <= 0, overflow <= 0. clear wins over char_valid in the same cycle; that char is dropped.
//  Refresh: the counter runs 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the index advances.
//   The index wraps from NUM_DIGITS-1 to 0. clear and char_valid do not disturb the counter or the index.
//  Outputs: an, seg and dp are registered and update together in the cycle after the index or buffer changes.
//   Exactly one an bit is low, at position = index, except during reset.
//  Decode (active low):
//   Digits and letters use the standard glyph table.
//   63 -> 7'h7F (all segments off).
//   36-62 -> 7'b0111111 ('-', error glyph).
//  dp: low only while index == NUM_DIGITS-1 and overflow = 1, marking that text has scrolled off.
//  Reset mid-scan forces the reset values on the next edge; the scan restarts at digit 0.
//  Latency: char_valid at edge N updates buf; the new glyph appears on seg by edge N+1 if digit 0 is being scanned.
//  Width: codes wider than 6 bits are compared on the low 6 bits only.
// TESTING  (REFRESH_DIV=4, NUM_DIGITS=4)
//  Reset, then run 16 cycles -> an steps through 1110, 1101, 1011, 0111 at 4 cycles each; seg = 7'h7F throughout; dp = 1.
//  Send codes 0, 1, 10, 14 -> digits 3..0 show 7'b1000000, 7'b1111001, 7'b0001000, 7'b0000110; char_count = 4; dp = 1.
//  Send a 5th code 40 -> buffer shifts; digit 0 shows 7'b0111111 and digit 3 shows '1'; dp = 0 while an = 0111.
//  Assert clear and char_valid together -> all digits blank; char_count = 0; dp = 1; the scan index is unchanged.
//  Assert rst mid-scan on digit 2 -> next cycle an = 1111, seg = 7'h7F; after release the scan restarts at an = 1110.
//  Send back-to-back char_valid on 6 consecutive cycles -> the last 4 codes are shown in order; char_count saturates at 4.

Source files
------------

// File: rtl/morse_char_display.sv
// Scrolling multi-digit seven-segment driver for decoded Morse characters.
// Keeps the last NUM_DIGITS codes in a shift buffer and time-multiplexes them
// onto a shared active-low segment bus with per-digit active-low anodes.
module morse_char_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CODE_W      = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               char_valid,
  input  logic [CODE_W-1:0]                  char_code,
  input  logic                               clear,
  output logic [NUM_DIGITS-1:0]              an,
  output logic [6:0]                         seg,
  output logic                               dp,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    char_count
);

  localparam int unsigned CHR_W = 6;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam logic [CHR_W-1:0] BLANK = 6'd63;

  logic [CHR_W-1:0]      chr_q [NUM_DIGITS];
  logic [CHR_W-1:0]      chr_d [NUM_DIGITS];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [REF_W-1:0]      refresh_q, refresh_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  // Active-low glyph lookup, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] glyph(input logic [CHR_W-1:0] c);
    logic [6:0] g;
    case (c)
      6'd0:  g = 7'b1000000;
      6'd1:  g = 7'b1111001;
      6'd2:  g = 7'b0100100;
      6'd3:  g = 7'b0110000;
      6'd4:  g = 7'b0011001;
      6'd5:  g = 7'b0010010;
      6'd6:  g = 7'b0000010;
      6'd7:  g = 7'b1111000;
      6'd8:  g = 7'b0000000;
      6'd9:  g = 7'b0010000;
      6'd10: g = 7'b0001000;
      6'd11: g = 7'b0000011;
      6'd12: g = 7'b1000110;
      6'd13: g = 7'b0100001;
      6'd14: g = 7'b0000110;
      6'd15: g = 7'b0001110;
      6'd16: g = 7'b1000010;
      6'd17: g = 7'b0001001;
      6'd18: g = 7'b1001111;
      6'd19: g = 7'b1100001;
      6'd20: g = 7'b0001010;
      6'd21: g = 7'b1000111;
      6'd22: g = 7'b1001000;
      6'd23: g = 7'b0101011;
      6'd24: g = 7'b0100011;
      6'd25: g = 7'b0001100;
      6'd26: g = 7'b0011000;
      6'd27: g = 7'b0101111;
      6'd28: g = 7'b0010010;
      6'd29: g = 7'b0000111;
      6'd30: g = 7'b1000001;
      6'd31: g = 7'b1100011;
      6'd32: g = 7'b1010101;
      6'd33: g = 7'b0001001;
      6'd34: g = 7'b0010001;
      6'd35: g = 7'b0100100;
      6'd63: g = 7'b1111111;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  // Refresh counter and digit index; independent of clear/char_valid.
  always_comb begin
    refresh_d = refresh_q;
    idx_d     = idx_q;
    if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      refresh_d = refresh_q + REF_W'(1);
    end
  end

  // Character buffer, fill count and overflow flag; clear beats a new char.
  always_comb begin
    chr_d   = chr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) chr_d[i] = BLANK;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (char_valid) begin
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) chr_d[i] = chr_q[i-1];
      chr_d[0] = CHR_W'(char_code);
      if (count_q == CNT_W'(NUM_DIGITS)) ovf_d = 1'b1;
      else count_d = count_q + CNT_W'(1);
    end
  end

  // Display outputs derived from the current index and buffer contents.
  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = glyph(chr_q[idx_q]);
    dp_d  = ~((idx_q == IDX_W'(NUM_DIGITS - 1)) && ovf_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) chr_q[i] <= BLANK;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      chr_q     <= chr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign char_count = count_q;

endmodule

// File: tb/tb_morse_char_display.sv
// Self-checking bench for morse_char_display: directed scenarios plus random
// traffic, every cycle compared against a queue-based behavioural model.
module tb_morse_char_display;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          char_valid = 1'b0;
  logic [CW-1:0] char_code = '0;
  logic          clear = 1'b0;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic [2:0]    char_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: newest char at the front of the queue.
  int m_chars[$];
  int m_cnt;
  bit m_ovf;
  int m_t;

  localparam logic [6:0] GLYPH [36] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b1000010, 7'b0001001,
    7'b1001111, 7'b1100001, 7'b0001010, 7'b1000111, 7'b1001000, 7'b0101011,
    7'b0100011, 7'b0001100, 7'b0011000, 7'b0101111, 7'b0010010, 7'b0000111,
    7'b1000001, 7'b1100011, 7'b1010101, 7'b0001001, 7'b0010001, 7'b0100100
  };

  morse_char_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .CODE_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_code  (char_code),
    .clear      (clear),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int c);
    if (c == 63) return 7'h7F;
    if (c > 35)  return 7'b0111111;
    return GLYPH[c];
  endfunction

  task automatic model_blank();
    m_chars.delete();
    for (int i = 0; i < ND; i++) m_chars.push_back(63);
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic cl, input logic r);
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;
    logic          e_dp;
    int            idx;
    @(negedge clk);
    char_valid = v;
    char_code  = c;
    clear      = cl;
    rst        = r;
    @(posedge clk);
    if (r) begin
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      m_t   = 0;
      model_blank();
    end else begin
      idx   = (m_t / RD) % ND;
      e_an  = ~(ND'(1) << idx);
      e_seg = ref_glyph(m_chars[idx]);
      e_dp  = !(idx == ND - 1 && m_ovf);
      m_t++;
      if (cl) begin
        model_blank();
      end else if (v) begin
        if (m_cnt == ND) m_ovf = 1'b1;
        m_chars.push_front(int'(c) % 64);
        void'(m_chars.pop_back());
        if (m_cnt < ND) m_cnt++;
      end
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("char_count", 32'(char_count), 32'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Idle until the given anode pattern is shown, bounded.
  task automatic wait_digit(input logic [ND-1:0] target);
    bit found = 1'b0;
    for (int i = 0; i < 4 * ND * RD && !found; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (an === target) found = 1'b1;
    end
    check("wait_digit", 32'(found), 32'd1);
  endtask

  initial begin
    m_t = 0;
    model_blank();

    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(16);

    step(1'b1, 6'd0, 1'b0, 1'b0);
    step(1'b1, 6'd1, 1'b0, 1'b0);
    step(1'b1, 6'd10, 1'b0, 1'b0);
    step(1'b1, 6'd14, 1'b0, 1'b0);
    wait_digit(4'b0111);
    check("digit3_zero", 32'(seg), 32'(7'b1000000));
    check("dp_no_ovf", 32'(dp), 32'd1);
    check("count_full", 32'(char_count), 32'd4);
    wait_digit(4'b1110);
    check("digit0_E", 32'(seg), 32'(7'b0000110));

    step(1'b1, 6'd40, 1'b0, 1'b0);
    wait_digit(4'b0111);
    check("digit3_one", 32'(seg), 32'(7'b1111001));
    check("dp_ovf", 32'(dp), 32'd0);
    wait_digit(4'b1110);
    check("digit0_err", 32'(seg), 32'(7'b0111111));
    idle(8);

    step(1'b1, 6'd5, 1'b1, 1'b0);
    check("clear_count", 32'(char_count), 32'd0);
    idle(16);

    wait_digit(4'b1011);
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_an", 32'(an), 32'hF);
    step(1'b0, '0, 1'b0, 1'b0);
    check("restart_an", 32'(an), 32'hE);

    for (int i = 0; i < 6; i++) step(1'b1, 6'($urandom_range(0, 35)), 1'b0, 1'b0);
    check("sat_count", 32'(char_count), 32'd4);
    idle(16);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 3) == 0, 6'($urandom % 64),
           ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    idle(16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
